// File: rtl/mdu_seq.sv
// Iterative MIPS multiply/divide unit owning HI/LO; N+2 cycle latency for mult/div.
// Define MDU_MADD_EN to enable madd/maddu (ops 110/111) accumulating into {hi,lo}.
module mdu_seq #(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic         dbz,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  localparam int CW = $clog2(N);
  localparam logic [2:0] OP_MTHI = 3'b100;
  localparam logic [2:0] OP_MTLO = 3'b101;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t         state_reg;
  logic [CW-1:0]  cnt_reg;
  logic           prep_reg;
  logic [2:0]     op_reg;
  logic [N-1:0]   a_reg, b_reg, m_reg;
  logic [2*N-1:0] p_reg;
  logic [N-1:0]   hi_reg, lo_reg;
  logic           busy_reg, done_reg, dbz_reg;

  logic           is_div, is_signed, a_neg, b_neg, dbz_hit, launch;
  logic [N-1:0]   a_abs, b_abs, quot_fix, rem_fix;
  logic [N:0]     mul_sum, div_shift, div_diff;
  logic [2*N-1:0] mul_next, div_next, prod_signed, fix_result;

  assign is_div    = (op_reg[2:1] == 2'b01);
  assign is_signed = ~op_reg[0];
  assign a_neg     = is_signed & a_reg[N-1];
  assign b_neg     = is_signed & b_reg[N-1];
  assign a_abs     = a_neg ? -a_reg : a_reg;
  assign b_abs     = b_neg ? -b_reg : b_reg;
  assign dbz_hit   = is_div && (b_reg == '0);

  // p_reg holds {partial product, multiplier} or {remainder, dividend/quotient}
  always_comb begin
    mul_sum   = {1'b0, p_reg[2*N-1:N]} + (p_reg[0] ? {1'b0, m_reg} : '0);
    mul_next  = {mul_sum, p_reg[N-1:1]};
    div_shift = {p_reg[2*N-1:N], p_reg[N-1]};
    div_diff  = div_shift - {1'b0, m_reg};
    div_next  = div_diff[N] ? {div_shift[N-1:0], p_reg[N-2:0], 1'b0}
                            : {div_diff[N-1:0],  p_reg[N-2:0], 1'b1};
  end

  assign prod_signed = (a_neg ^ b_neg) ? -p_reg : p_reg;
  assign quot_fix    = (a_neg ^ b_neg) ? -p_reg[N-1:0] : p_reg[N-1:0];
  assign rem_fix     = a_neg ? -p_reg[2*N-1:N] : p_reg[2*N-1:N];

  always_comb begin
    fix_result = prod_signed;
    if (is_div)
      fix_result = dbz_hit ? {a_reg, {N{1'b1}}} : {rem_fix, quot_fix};
`ifdef MDU_MADD_EN
    else if (op_reg[2])
      fix_result = {hi_reg, lo_reg} + prod_signed;
`endif
  end

  always_comb begin
    launch = ~op[2];
`ifdef MDU_MADD_EN
    if (op[2:1] == 2'b11) launch = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      prep_reg  <= 1'b0;
      op_reg    <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
      m_reg     <= '0;
      p_reg     <= '0;
      hi_reg    <= '0;
      lo_reg    <= '0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      dbz_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      dbz_reg  <= 1'b0;
      if (flush && state_reg != IDLE) begin
        state_reg <= IDLE;
        busy_reg  <= 1'b0;
        prep_reg  <= 1'b0;
      end else begin
        case (state_reg)
          IDLE: begin
            if (start) begin
              if (op == OP_MTHI) begin
                hi_reg <= a;
              end else if (op == OP_MTLO) begin
                lo_reg <= a;
              end else if (launch) begin
                op_reg    <= op;
                a_reg     <= a;
                b_reg     <= b;
                cnt_reg   <= CW'(N-1);
                prep_reg  <= 1'b1;
                busy_reg  <= 1'b1;
                state_reg <= RUN;
              end
            end
          end
          RUN: begin
            // RUN opens with one operand-conditioning cycle before the N iterations
            if (prep_reg) begin
              m_reg    <= is_div ? b_abs : a_abs;
              p_reg    <= {{N{1'b0}}, (is_div ? a_abs : b_abs)};
              prep_reg <= 1'b0;
            end else begin
              p_reg <= is_div ? div_next : mul_next;
              if (cnt_reg == '0) state_reg <= FIX;
              else cnt_reg <= cnt_reg - CW'(1);
            end
          end
          FIX: begin
            {hi_reg, lo_reg} <= fix_result;
            done_reg  <= 1'b1;
            dbz_reg   <= dbz_hit;
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  assign dbz  = dbz_reg;
  assign hi   = hi_reg;
  assign lo   = lo_reg;

endmodule

// File: doc/mdu_seq.md
Name: mdu_seq

Overview:
Iterative multiply/divide unit that sits beside the combinational ALU in the EX stage. Executes MIPS MULT/MULTU/DIV/DIVU over N+2 cycles and owns the architectural HI/LO registers. Supports MTHI/MTLO writes. The pipeline stalls on busy and reads hi/lo directly for MFHI/MFLO. Width is parametrised.

Parameters:
N, 32, operand width; HI and LO are N bits each; N >= 4, even.

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
start  in  1  request; sampled only when busy=0
op  in  3  000 mult, 001 multu, 010 div, 011 divu, 100 mthi, 101 mtlo, 110 madd*, 111 maddu*
a  in  N  operand rs (dividend / multiplicand / mthi-mtlo source)
b  in  N  operand rt (divisor / multiplier)
flush  in  1  synchronous abort of the in-flight operation
busy  out  1  operation in progress
done  out  1  one-cycle pulse; HI/LO updated this cycle
dbz  out  1  divide-by-zero flag, valid with done
hi  out  N  HI register
lo  out  N  LO register

Behaviour:
- Reset (rst_n=0, async): state=IDLE; busy=0, done=0, dbz=0, hi=0, lo=0; internal regs cleared. Any operation in flight is lost.
- States: IDLE -> RUN (N iterations, counter N-1..0) -> FIX (1 cycle) -> IDLE.
- Accepting a request:
  - start is accepted only in IDLE, or in the cycle done=1 (back-to-back issue).
  - start while busy=1 is ignored, with no side effects.
- Timing for mult/multu/div/divu/madd/maddu:
  - start sampled at edge k; busy=1 for cycles k..k+N+1.
  - At edge k+N+2: hi/lo written, done=1 for one cycle, busy=0.
  - Total latency is N+2 cycles. For N=32, done rises 34 cycles after start.
- mthi/mtlo:
  - Write a to hi/lo at the accepting edge.
  - busy and done stay 0; no stall.
- Multiply:
  - Shift-add over operand magnitudes; one bit per RUN cycle.
  - Signed ops negate the 2N-bit product in FIX when the operand signs differ.
  - {hi,lo} = full 2N-bit product.
- Divide:
  - Restoring division over magnitudes; one quotient bit per RUN cycle.
  - Quotient truncates toward zero. Remainder takes the sign of the dividend.
  - lo = quotient, hi = remainder.
- Boundary cases:
  - b=0 on div/divu: the divide still runs the full latency. Result lo = all ones, hi = a. dbz=1 together with done; otherwise dbz=0.
  - div of -2^(N-1) by -1: lo = -2^(N-1) (wraps), hi = 0, dbz = 0. No trap; overflow is not signalled.
- Flush:
  - flush=1 while busy: return to IDLE at the next edge. busy=0; done never pulses; hi/lo unchanged.
  - flush has priority over start in the same cycle.
  - flush in IDLE has no effect.
- Operand capture: a, b and op are registered at accept and may change afterwards.

Optional Feature:
MDU_MADD_EN
- Defined:
  - op 110/111 run signed/unsigned multiply and accumulate {hi,lo} += product, mod 2^(2N).
  - The accumulate happens in the FIX cycle, so latency is unchanged.
- Undefined:
  - op 110/111 are treated as no-ops: accepted, busy stays 0, hi/lo unchanged, done=0.

Test Plan:
- multu a=0xFFFFFFFF b=0xFFFFFFFF (N=32) -> done at start+34, hi=0xFFFFFFFE, lo=0x00000001, busy high for 34 cycles.
- mult a=0xFFFFFFFD (-3) b=5 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1.
- div a=0xFFFFFFF9 (-7) b=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Then div a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000, hi=0, dbz=0.
- divu a=10 b=0 -> hi=0x0000000A, lo=0xFFFFFFFF, dbz=1 for exactly the done cycle.
- Start multu, assert flush at start+5, and pulse start with op=mthi at start+3 -> busy=0 at start+6, no done, hi/lo keep their prior values, ignored mthi leaves hi unchanged. Then mthi a=0x1234 in IDLE -> hi=0x1234 next cycle, busy stays 0.
- With MDU_MADD_EN: mtlo 1, mthi 0, then maddu a=2 b=3 -> hi=0, lo=7 at start+34. Without the macro: same stimulus -> lo=1, no done.
